// File: rtl/moving_average_fifo_filter_pkg.sv
// Shared helpers for the moving-average filter: accumulator sizing.
package filter_pkg;

  // A sum of 2**log2_depth samples of data_w bits needs log2_depth extra bits.
  function automatic int avg_sum_width(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

endpackage

// File: rtl/moving_average_fifo_filter_if.sv
// Sample/result bundle between a producer and the moving-average filter.
interface moving_average_fifo_filter_if #(
  parameter int DATA_W     = 24,
  parameter int LOG2_DEPTH = 3
);
  logic                     en;
  logic                     clear;
  logic signed [DATA_W-1:0] data_in;
  logic signed [DATA_W-1:0] data_out;
  logic                     out_valid;
  logic                     filled;
  logic [LOG2_DEPTH:0]      count;

  modport master (
    output en, clear, data_in,
    input  data_out, out_valid, filled, count
  );

  modport slave (
    input  en, clear, data_in,
    output data_out, out_valid, filled, count
  );
endinterface

// File: rtl/moving_average_fifo_filter_ring_buffer.sv
// Circular sample store for the averaging window; owns write pointer, fill count and fill flag.
module sample_ring_buffer #(
  parameter int DATA_W     = 24,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic signed [DATA_W-1:0] wr_data,
  output logic signed [DATA_W-1:0] oldest,
  output logic [LOG2_DEPTH-1:0]    wp,
  output logic [LOG2_DEPTH:0]      count,
  output logic                     filled
);
  localparam int                  DEPTH   = 2**LOG2_DEPTH;
  localparam logic [LOG2_DEPTH:0] DEPTH_C = (LOG2_DEPTH+1)'(DEPTH);

  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0]    wp_q, wp_d;
  logic [LOG2_DEPTH:0]      count_q, count_d;
  logic                     filled_q, filled_d;

  // Once full, the slot about to be overwritten holds the sample leaving the window.
  // Before that the slot may be stale or never written, so it must read as zero.
  assign oldest = filled_q ? mem_q[wp_q] : '0;

  always_comb begin
    wp_d     = wp_q;
    count_d  = count_q;
    filled_d = filled_q;
    if (clear) begin
      wp_d     = '0;
      count_d  = '0;
      filled_d = 1'b0;
    end else if (wr_en) begin
      wp_d     = wp_q + LOG2_DEPTH'(1);
      count_d  = (count_q == DEPTH_C) ? DEPTH_C : count_q + (LOG2_DEPTH+1)'(1);
      filled_d = filled_q | (count_q + (LOG2_DEPTH+1)'(1) == DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q     <= '0;
      count_q  <= '0;
      filled_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      count_q  <= count_d;
      filled_q <= filled_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !clear && wr_en) begin
      mem_q[wp_q] <= wr_data;
    end
  end

  assign wp     = wp_q;
  assign count  = count_q;
  assign filled = filled_q;
endmodule

// File: rtl/moving_average_fifo_filter.sv
// N-point moving-average filter: running window sum, floor-divide by shift, registered result.
module moving_average_fifo_filter
  import filter_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int LOG2_DEPTH = 3,
  parameter int ZERO_FILL  = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  moving_average_fifo_filter_if.slave  bus
);
  localparam int SUM_W = avg_sum_width(DATA_W, LOG2_DEPTH);
  localparam int DEPTH = 2**LOG2_DEPTH;

  logic signed [DATA_W-1:0] din_p0;
  logic signed [DATA_W-1:0] oldest_p0;
  logic signed [SUM_W-1:0]  din_ext_p0, old_ext_p0, next_sum_p0;
  logic [LOG2_DEPTH-1:0]    ring_wp_unused;
  logic [LOG2_DEPTH:0]      count_p0;
  logic [LOG2_DEPTH+1:0]    count_inc_p0;
  logic                     filled_p0;
  logic                     reach_full_p0;

  logic signed [SUM_W-1:0]  sum_q, sum_d;
  logic signed [DATA_W-1:0] data_p1_q, data_p1_d;
  logic                     vld_p1_q, vld_p1_d;

  function automatic logic signed [DATA_W-1:0] avg_floor(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] sh;
    sh = s >>> LOG2_DEPTH;
    return sh[DATA_W-1:0];
  endfunction

  sample_ring_buffer #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk     (clk),
    .reset   (reset),
    .clear   (bus.clear),
    .wr_en   (bus.en),
    .wr_data (din_p0),
    .oldest  (oldest_p0),
    .wp      (ring_wp_unused),
    .count   (count_p0),
    .filled  (filled_p0)
  );

  // Stage p0: combine the incoming sample with the one leaving the window.
  assign din_p0        = bus.data_in;
  assign din_ext_p0    = {{LOG2_DEPTH{din_p0[DATA_W-1]}}, din_p0};
  assign old_ext_p0    = {{LOG2_DEPTH{oldest_p0[DATA_W-1]}}, oldest_p0};
  assign next_sum_p0   = sum_q + din_ext_p0 - old_ext_p0;
  assign count_inc_p0  = {1'b0, count_p0} + (LOG2_DEPTH+2)'(1);
  assign reach_full_p0 = count_inc_p0 >= (LOG2_DEPTH+2)'(DEPTH);

  always_comb begin
    sum_d     = sum_q;
    data_p1_d = data_p1_q;
    vld_p1_d  = 1'b0;
    if (bus.clear) begin
      sum_d = '0;
    end else if (bus.en) begin
      sum_d     = next_sum_p0;
      data_p1_d = avg_floor(next_sum_p0);
      vld_p1_d  = (ZERO_FILL != 0) || reach_full_p0;
    end
  end

  // Stage p1: registered average and its valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q     <= '0;
      data_p1_q <= '0;
      vld_p1_q  <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      data_p1_q <= data_p1_d;
      vld_p1_q  <= vld_p1_d;
    end
  end

  assign bus.data_out  = data_p1_q;
  assign bus.out_valid = vld_p1_q;
  assign bus.count     = count_p0;
  assign bus.filled    = filled_p0;
endmodule

// File: tb/tb_moving_average_fifo_filter.sv
// Randomised and directed checks of the moving-average filter against a window-queue model.
module tb_moving_average_fifo_filter;
  localparam int DW = 8;
  localparam int L2 = 2;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic reset_r = 1'b1;
  logic en_r = 1'b0;
  logic clr_r = 1'b0;
  logic signed [DW-1:0] din_r = '0;

  int total = 0;
  int bad = 0;

  // Model: the samples currently in the window, oldest first.
  int win[$];
  logic signed [DW-1:0] exp_d0 = '0, exp_d1 = '0;
  logic exp_v0 = 1'b0, exp_v1 = 1'b0;

  always #5 clk = ~clk;

  moving_average_fifo_filter_if #(.DATA_W(DW), .LOG2_DEPTH(L2)) if0 ();
  moving_average_fifo_filter_if #(.DATA_W(DW), .LOG2_DEPTH(L2)) if1 ();

  assign if0.en = en_r;  assign if0.clear = clr_r;  assign if0.data_in = din_r;
  assign if1.en = en_r;  assign if1.clear = clr_r;  assign if1.data_in = din_r;

  moving_average_fifo_filter #(.DATA_W(DW), .LOG2_DEPTH(L2), .ZERO_FILL(0)) dut0 (
    .clk(clk), .reset(reset_r), .bus(if0.slave));
  moving_average_fifo_filter #(.DATA_W(DW), .LOG2_DEPTH(L2), .ZERO_FILL(1)) dut1 (
    .clk(clk), .reset(reset_r), .bus(if1.slave));

  function automatic int floor_avg(input int s);
    int q;
    q = s / D;
    if ((s % D != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  task automatic step(input logic r, input logic e, input logic c, input int d);
    int s;
    logic signed [DW-1:0] t;
    t = d[DW-1:0];
    reset_r = r; en_r = e; clr_r = c; din_r = t;
    @(posedge clk);
    if (r) begin
      win.delete();
      exp_d0 = '0; exp_d1 = '0; exp_v0 = 1'b0; exp_v1 = 1'b0;
    end else if (c) begin
      win.delete();
      exp_v0 = 1'b0; exp_v1 = 1'b0;
    end else if (e) begin
      win.push_back(int'(t));
      if (win.size() > D) void'(win.pop_front());
      s = 0;
      foreach (win[i]) s += win[i];
      exp_d0 = DW'(floor_avg(s));
      exp_d1 = exp_d0;
      exp_v0 = (win.size() == D);
      exp_v1 = 1'b1;
    end else begin
      exp_v0 = 1'b0; exp_v1 = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset;
    step(1, 1, 0, 5);
    step(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step(0, 0, 0, 0);
      total += 4;
      if (if0.data_out !== 8'sd0) begin bad++; $display("FAIL reset_dout k=%0d got=%0d want=0", k, if0.data_out); end
      if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL reset_vld k=%0d got=%b want=0", k, if0.out_valid); end
      if (if0.count !== 3'd0) begin bad++; $display("FAIL reset_count k=%0d got=%0d want=0", k, if0.count); end
      if (if0.filled !== 1'b0) begin bad++; $display("FAIL reset_filled k=%0d got=%b want=0", k, if0.filled); end
    end
  endtask

  task automatic test_fill;
    int vals[4] = '{4, 8, 12, 16};
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, vals[k]);
      total++;
      if (if0.out_valid !== (k == 3)) begin bad++; $display("FAIL fill_vld k=%0d got=%b want=%b", k, if0.out_valid, (k == 3)); end
    end
    total += 3;
    if (if0.data_out !== 8'sd10) begin bad++; $display("FAIL fill_dout got=%0d want=10", if0.data_out); end
    if (if0.count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", if0.count); end
    if (if0.filled !== 1'b1) begin bad++; $display("FAIL fill_filled got=%b want=1", if0.filled); end
  endtask

  task automatic test_wrap;
    step(0, 1, 0, 20);
    total += 2;
    if (if0.data_out !== 8'sd14 || if0.out_valid !== 1'b1) begin bad++; $display("FAIL wrap1 got=%0d/%b want=14/1", if0.data_out, if0.out_valid); end
    if (if0.count !== 3'd4) begin bad++; $display("FAIL wrap1_count got=%0d want=4", if0.count); end
    step(0, 1, 0, 24);
    total++;
    if (if0.data_out !== 8'sd18 || if0.out_valid !== 1'b1) begin bad++; $display("FAIL wrap2 got=%0d/%b want=18/1", if0.data_out, if0.out_valid); end
    // Six more samples push wp round the ring again.
    for (int k = 0; k < 6; k++) begin
      step(0, 1, 0, 28 + 4 * k);
      total++;
      if (if0.data_out !== exp_d0) begin bad++; $display("FAIL wrap_run k=%0d got=%0d want=%0d", k, if0.data_out, exp_d0); end
    end
  endtask

  task automatic test_signed;
    step(0, 0, 1, 0);
    for (int k = 0; k < 4; k++) step(0, 1, 0, -8);
    total++;
    if (if0.data_out !== -8'sd8 || if0.out_valid !== 1'b1) begin bad++; $display("FAIL signed_m8 got=%0d/%b want=-8/1", if0.data_out, if0.out_valid); end
    step(0, 0, 1, 0);
    step(0, 1, 0, -3);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    total++;
    if (if0.data_out !== -8'sd1) begin bad++; $display("FAIL signed_floor got=%0d want=-1", if0.data_out); end
  endtask

  task automatic test_zero_fill;
    step(0, 0, 1, 0);
    step(0, 1, 0, 8);
    total += 2;
    if (if1.out_valid !== 1'b1 || if1.data_out !== 8'sd2) begin bad++; $display("FAIL zf1 got=%0d/%b want=2/1", if1.data_out, if1.out_valid); end
    if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL zf1_nozf_vld got=%b want=0", if0.out_valid); end
    step(0, 1, 0, 8);
    total += 3;
    if (if1.out_valid !== 1'b1 || if1.data_out !== 8'sd4) begin bad++; $display("FAIL zf2 got=%0d/%b want=4/1", if1.data_out, if1.out_valid); end
    if (if1.count !== 3'd2) begin bad++; $display("FAIL zf_count got=%0d want=2", if1.count); end
    if (if1.filled !== 1'b0) begin bad++; $display("FAIL zf_filled got=%b want=0", if1.filled); end
  endtask

  task automatic test_clear_collision;
    step(0, 0, 1, 0);
    step(0, 1, 0, 4); step(0, 1, 0, 8); step(0, 1, 0, 12); step(0, 1, 0, 16);
    step(0, 1, 1, 100);
    total += 3;
    if (if0.count !== 3'd0) begin bad++; $display("FAIL clr_count got=%0d want=0", if0.count); end
    if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL clr_vld got=%b want=0", if0.out_valid); end
    if (if0.data_out !== 8'sd10) begin bad++; $display("FAIL clr_hold got=%0d want=10", if0.data_out); end
    for (int k = 0; k < 4; k++) step(0, 1, 0, 1);
    total++;
    if (if0.data_out !== 8'sd1 || if0.out_valid !== 1'b1) begin bad++; $display("FAIL clr_refill got=%0d/%b want=1/1", if0.data_out, if0.out_valid); end
    step(0, 1, 0, 50);
    step(1, 1, 1, 77);
    total += 4;
    if (if0.data_out !== 8'sd0) begin bad++; $display("FAIL mid_reset_dout got=%0d want=0", if0.data_out); end
    if (if0.out_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_vld got=%b want=0", if0.out_valid); end
    if (if0.count !== 3'd0) begin bad++; $display("FAIL mid_reset_count got=%0d want=0", if0.count); end
    if (if0.filled !== 1'b0) begin bad++; $display("FAIL mid_reset_filled got=%b want=0", if0.filled); end
  endtask

  task automatic test_random;
    logic r, e, c;
    int d;
    for (int k = 0; k < 500; k++) begin
      r = ($urandom_range(0, 63) == 0);
      c = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 3) != 0);
      d = int'($urandom_range(0, 255));
      step(r, e, c, d);
      total++;
      if (if0.data_out !== exp_d0 || if0.out_valid !== exp_v0 ||
          if1.data_out !== exp_d1 || if1.out_valid !== exp_v1 ||
          if0.count !== 3'(win.size()) || if1.count !== 3'(win.size()) ||
          if0.filled !== (win.size() == D) || if1.filled !== (win.size() == D)) begin
        bad++;
        $display("FAIL rand k=%0d got d0=%0d v0=%b d1=%0d v1=%b cnt=%0d fl=%b want d0=%0d v0=%b d1=%0d v1=%b cnt=%0d fl=%b",
                 k, if0.data_out, if0.out_valid, if1.data_out, if1.out_valid, if0.count, if0.filled,
                 exp_d0, exp_v0, exp_d1, exp_v1, win.size(), (win.size() == D));
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_signed();
    test_zero_fill();
    test_clear_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
